// File: rtl/fp_result_shifter.sv
// Serial read-out of a captured binary32 result plus exception flags, MSB first,
// advanced by a debounced-edge step key or an internal auto-tick.
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | nothing loaded, outputs quiet
// ST_SHOW | frame loaded, presenting sreg MSB at bit_idx
// ST_DONE | last bit stepped past, waiting for a new capture
module fp_result_shifter #(
    parameter int FLEN     = 32,
    parameter int W_FLAGS  = 5,
    parameter int AUTO_DIV = 25_000_000,
    parameter int W_IDX    = $clog2(FLEN + W_FLAGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic [FLEN-1:0]    in_data,
    input  logic [W_FLAGS-1:0] in_flags,
    input  logic               step,
    input  logic               auto,
    output logic               ser_out,
    output logic               ser_valid,
    output logic [W_IDX-1:0]   bit_idx,
    output logic               busy,
    output logic               done
);

    localparam int N     = FLEN + W_FLAGS;
    localparam int W_CNT = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;

    localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(N - 1);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(AUTO_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [N-1:0]     sreg, sreg_nxt;
    logic [W_IDX-1:0] idx_nxt;
    logic             s1, s2, s3;
    logic             step_evt;
    logic [W_CNT-1:0] tick_cnt;
    logic             tick;
    logic             adv;

    assign step_evt = s2 & ~s3;
    assign tick     = auto && (state == ST_SHOW) && (tick_cnt == CNT_LAST);
    assign adv      = auto ? tick : step_evt;

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        idx_nxt   = bit_idx;
        // capture always wins over a coincident advance
        if (capture) begin
            state_nxt = ST_SHOW;
            sreg_nxt  = {in_flags, in_data};
            idx_nxt   = '0;
        end else if (state == ST_SHOW && adv) begin
            if (bit_idx == LAST_IDX) begin
                state_nxt = ST_DONE;
            end else begin
                sreg_nxt = {sreg[N-2:0], 1'b0};
                idx_nxt  = bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= step;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !auto || state != ST_SHOW) begin
            tick_cnt <= '0;
        end else if (tick_cnt == CNT_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // outputs are registered from the next-state values so they line up with state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bit_idx   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            bit_idx   <= idx_nxt;
            ser_out   <= (state_nxt == ST_SHOW) & sreg_nxt[N-1];
            ser_valid <= (state_nxt == ST_SHOW);
            busy      <= (state_nxt == ST_SHOW);
            done      <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_fp_result_shifter.sv
// Directed bench for fp_result_shifter: idle, full frame, held key, collision,
// mid-frame reset and auto-tick read-out (AUTO_DIV = 4).
module tb_fp_result_shifter;

    localparam int FLEN    = 32;
    localparam int W_FLAGS = 5;
    localparam int N       = FLEN + W_FLAGS;
    localparam int W_IDX   = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               capture = 1'b0;
    logic [FLEN-1:0]    in_data = '0;
    logic [W_FLAGS-1:0] in_flags = '0;
    logic               step = 1'b0;
    logic               auto_mode = 1'b0;
    logic               ser_out;
    logic               ser_valid;
    logic [W_IDX-1:0]   bit_idx;
    logic               busy;
    logic               done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [N-1:0] frame;

    fp_result_shifter #(
        .FLEN(FLEN),
        .W_FLAGS(W_FLAGS),
        .AUTO_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .capture(capture),
        .in_data(in_data),
        .in_flags(in_flags),
        .step(step),
        .auto(auto_mode),
        .ser_out(ser_out),
        .ser_valid(ser_valid),
        .bit_idx(bit_idx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_pulse();
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic load(input logic [FLEN-1:0] d, input logic [W_FLAGS-1:0] f);
        in_data  = d;
        in_flags = f;
        frame    = {f, d};
        capture  = 1'b1;
        cyc();
        capture  = 1'b0;
    endtask

    initial begin
        int exp_idx;
        logic exp_done;

        rst = 1'b1;
        cyc();
        cyc();
        chk("reset_outputs", 64'({ser_out, ser_valid, busy, done, bit_idx}), 64'd0);
        rst = 1'b0;

        // idle: step toggling does nothing
        for (int i = 0; i < 5; i++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            cyc();
            cyc();
            chk($sformatf("idle_%0d", i), 64'({ser_valid, done, bit_idx}), 64'd0);
        end

        // full frame, 1.5 with inexact flag
        load(32'h3FC0_0000, 5'b00001);
        chk("cap_valid", 64'(ser_valid), 64'd1);
        chk("cap_bit0", 64'(ser_out), 64'd0);
        chk("cap_idx", 64'(bit_idx), 64'd0);
        for (int i = 1; i < N; i++) begin
            step_pulse();
            chk($sformatf("frame_bit%0d", i), 64'(ser_out), 64'(frame[N-1-i]));
            chk($sformatf("frame_idx%0d", i), 64'(bit_idx), 64'(i));
        end
        chk("last_busy", 64'({busy, ser_valid, done}), 64'b110);
        step_pulse();
        chk("done_flags", 64'({done, ser_valid, busy, ser_out}), 64'b1000);
        chk("done_idx", 64'(bit_idx), 64'd36);
        step_pulse();
        chk("done_hold", 64'({done, bit_idx}), 64'({1'b1, 6'd36}));

        // held key: exactly one advance, landing 3 cycles after assertion
        load(32'h3FC0_0000, 5'b00001);
        chk("reload_idx", 64'(bit_idx), 64'd0);
        step = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            cyc();
            chk($sformatf("held_c%0d", c), 64'(bit_idx), (c >= 3) ? 64'd1 : 64'd0);
        end
        step = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("held_release", 64'(bit_idx), 64'd1);

        // capture collides with a step event at bit_idx 10
        for (int i = 2; i <= 10; i++) step_pulse();
        chk("pre_coll_idx", 64'(bit_idx), 64'd10);
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        load(32'h8000_0000, 5'b00000);
        chk("coll_idx", 64'(bit_idx), 64'd0);
        chk("coll_out", 64'({ser_valid, ser_out}), 64'b10);
        cyc();
        chk("coll_settle", 64'(bit_idx), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            step_pulse();
            chk($sformatf("coll_flag%0d", i), 64'({bit_idx, ser_out}), 64'({6'(i), 1'b0}));
        end
        step_pulse();
        chk("coll_sign", 64'({bit_idx, ser_out}), 64'({6'd5, 1'b1}));

        // mid-frame reset at bit_idx 20
        for (int i = 6; i <= 20; i++) step_pulse();
        chk("pre_rst_idx", 64'(bit_idx), 64'd20);
        rst = 1'b1;
        cyc();
        chk("midrst_out", 64'({ser_out, ser_valid, busy, done, bit_idx}), 64'd0);
        rst = 1'b0;
        cyc();
        chk("midrst_idle", 64'({ser_out, ser_valid, busy, done, bit_idx}), 64'd0);

        // auto mode: all-ones frame, one advance every 4 cycles, step ignored
        auto_mode = 1'b1;
        load(32'hFFFF_FFFF, 5'h1F);
        chk("auto_start", 64'({ser_valid, ser_out, bit_idx}), 64'({2'b11, 6'd0}));
        for (int c = 1; c <= 152; c++) begin
            step = ~step;
            cyc();
            exp_idx  = (c / 4 > 36) ? 36 : c / 4;
            exp_done = (c >= 148);
            chk($sformatf("auto_idx_c%0d", c), 64'(bit_idx), 64'(exp_idx));
            chk($sformatf("auto_st_c%0d", c), 64'({done, ser_valid, ser_out}),
                64'({exp_done, ~exp_done, ~exp_done}));
        end
        step = 1'b0;
        auto_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
